// File: rtl/adam_aes_ctr_pkg.sv
// Shared types, widths and the counter-block incrementer for the AES CTR-mode controller.
package adam_aes_ctr_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned KEY_W   = 256;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        OUTPUT    = 3'd4
    } state_t;

    // Increment only the low 'width' bits (mod 2^width); the nonce part above stays untouched.
    function automatic logic [BLOCK_W-1:0] ctr_inc(input logic [BLOCK_W-1:0] block,
                                                   input int unsigned        width);
        logic [BLOCK_W-1:0] mask;
        mask = {BLOCK_W{1'b1}} >> (BLOCK_W - width);
        return (block & ~mask) | ((block + {{(BLOCK_W-1){1'b0}}, 1'b1}) & mask);
    endfunction

endpackage

// File: rtl/adam_aes_ctr_ctrl.sv
// CTR-mode stream controller: drives one AES encrypt per input block and XORs the
// resulting keystream with the buffered block, one block in flight.
module adam_aes_ctr_ctrl
    import adam_aes_ctr_pkg::*;
#(
    parameter int unsigned CTR_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_load,
    input  logic [KEY_W-1:0]   cfg_key,
    input  logic               cfg_keylen,
    input  logic [BLOCK_W-1:0] cfg_iv,
    output logic               cfg_err,
    output logic               busy,
    output logic [31:0]        block_count,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_last,
    output logic               core_encdec,
    output logic               core_start,
    input  logic               core_ready,
    input  logic               core_result_valid,
    output logic [KEY_W-1:0]   core_key,
    output logic               core_keylen,
    output logic [BLOCK_W-1:0] core_block,
    input  logic [BLOCK_W-1:0] core_result
);

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] buf_q, buf_d;
    logic               buf_last_q, buf_last_d;
    logic [BLOCK_W-1:0] ctr_q, ctr_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               keylen_q, keylen_d;
    logic               cfg_err_q, cfg_err_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [BLOCK_W-1:0] out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               live_q;
    logic               idle_s;
    logic               accept_s;

    // live_q keeps in_ready low while reset is asserted even though the state reads IDLE.
    assign idle_s      = (state_q == IDLE);
    assign in_ready    = idle_s && !cfg_load && live_q;
    assign accept_s    = in_valid && in_ready;

    assign cfg_err     = cfg_err_q;
    assign busy        = !idle_s;
    assign block_count = cnt_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign core_encdec = 1'b1;
    assign core_key    = key_q;
    assign core_keylen = keylen_q;
    assign core_block  = ctr_q;

    // Next-state, configuration latch and datapath updates.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        buf_last_d  = buf_last_q;
        ctr_d       = ctr_q;
        key_d       = key_q;
        keylen_d    = keylen_q;
        cfg_err_d   = cfg_err_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        core_start  = 1'b0;

        if (cfg_load && idle_s) begin
            key_d     = cfg_key;
            keylen_d  = cfg_keylen;
            ctr_d     = cfg_iv;
            cnt_d     = 32'd0;
            cfg_err_d = 1'b0;
        end else if (cfg_load) begin
            cfg_err_d = 1'b1;
        end else begin
            cfg_err_d = cfg_err_q;
        end

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    buf_d      = in_data;
                    buf_last_d = in_last;
                    state_d    = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (core_ready) begin
                    core_start = 1'b1;
                    state_d    = WAIT_BUSY;
                end else begin
                    state_d = START;
                end
            end
            // A lingering result_valid from the previous operation must not count as done.
            WAIT_BUSY: begin
                if (!core_ready) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (core_ready && core_result_valid) begin
                    out_data_d  = core_result ^ buf_q;
                    out_last_d  = buf_last_q;
                    out_valid_d = 1'b1;
                    ctr_d       = ctr_inc(ctr_q, CTR_WIDTH);
                    cnt_d       = cnt_q + 32'd1;
                    state_d     = OUTPUT;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = OUTPUT;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            buf_last_q  <= 1'b0;
            ctr_q       <= '0;
            key_q       <= '0;
            keylen_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
            cnt_q       <= 32'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            buf_last_q  <= buf_last_d;
            ctr_q       <= ctr_d;
            key_q       <= key_d;
            keylen_q    <= keylen_d;
            cfg_err_q   <= cfg_err_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            live_q      <= 1'b1;
        end
    end

endmodule
